// File: rtl/freecell_pkg.sv
// Shared types and constants for the FreeCell engine: card encoding,
// location codes, board sizes and the initial deal.
package freecell_pkg;

    // Board dimensions
    localparam int NUM_COLS  = 8;
    localparam int NUM_FREE  = 4;
    localparam int NUM_HOME  = 4;
    localparam int COL_DEPTH = 19;
    localparam int NUM_CARDS = 52;

    localparam logic [3:0] RANK_KING = 4'd13;

    // Location code boundaries (0-7 columns, 8-11 free cells, 12-15 home)
    localparam logic [3:0] LOC_FREE_BASE = 4'd8;
    localparam logic [3:0] LOC_HOME_BASE = 4'd12;

    // A card: rank 0 means "no card"
    typedef struct packed {
        logic [1:0] suit;
        logic [3:0] rank;
    } card_t;

    typedef enum logic [1:0] {
        LOC_COL  = 2'd0,
        LOC_FREE = 2'd1,
        LOC_HOME = 2'd2
    } loc_kind_t;

    // Initial deal: entry k has rank 13 - k/4 and suit k mod 4
    localparam card_t INIT_DEAL [0:NUM_CARDS-1] = '{
        6'h0D, 6'h1D, 6'h2D, 6'h3D,
        6'h0C, 6'h1C, 6'h2C, 6'h3C,
        6'h0B, 6'h1B, 6'h2B, 6'h3B,
        6'h0A, 6'h1A, 6'h2A, 6'h3A,
        6'h09, 6'h19, 6'h29, 6'h39,
        6'h08, 6'h18, 6'h28, 6'h38,
        6'h07, 6'h17, 6'h27, 6'h37,
        6'h06, 6'h16, 6'h26, 6'h36,
        6'h05, 6'h15, 6'h25, 6'h35,
        6'h04, 6'h14, 6'h24, 6'h34,
        6'h03, 6'h13, 6'h23, 6'h33,
        6'h02, 6'h12, 6'h22, 6'h32,
        6'h01, 6'h11, 6'h21, 6'h31
    };

    // Diamonds and hearts are red
    function automatic logic is_red(card_t c);
        return c.suit[1] ^ c.suit[0];
    endfunction

    // Classify a 4-bit location code
    function automatic loc_kind_t loc_kind(logic [3:0] loc);
        if (!loc[3])
            return LOC_COL;
        else if (!loc[2])
            return LOC_FREE;
        else
            return LOC_HOME;
    endfunction

endpackage

// File: rtl/freecell_move_check.sv
// Combinational legality check for a single-card move.
module freecell_move_check
    import freecell_pkg::*;
(
    input  card_t      src_card,
    input  logic       src_ok,
    input  loc_kind_t  dest_kind,
    input  card_t      dest_card,
    input  logic       dest_room,
    input  logic [3:0] home_rank,
    output logic       legal
);

    // Decide whether the source card may be placed at the destination
    always_comb begin
        legal = 1'b0;
        if (src_ok && (src_card.rank != 4'd0)) begin
            case (dest_kind)
                LOC_COL: begin
                    // Empty column takes anything; otherwise descending, alternating colour
                    legal = dest_room &&
                            ((dest_card.rank == 4'd0) ||
                             (({1'b0, dest_card.rank} == ({1'b0, src_card.rank} + 5'd1)) &&
                              (is_red(dest_card) != is_red(src_card))));
                end
                LOC_FREE: begin
                    legal = (dest_card.rank == 4'd0);
                end
                default: begin
                    // Home accepts the next rank of the card's own suit
                    legal = (({1'b0, home_rank} + 5'd1) == {1'b0, src_card.rank});
                end
            endcase
        end
    end

endmodule

// File: rtl/my_freecell.sv
// FreeCell game engine: holds the board, applies one legal move per clock,
// and flags a win once every home cell holds its king.
module my_freecell
    import freecell_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] source,
    input  logic [3:0] dest,
    output logic       win
);

    card_t      cols   [NUM_COLS][COL_DEPTH];
    logic [4:0] height [NUM_COLS];
    card_t      free   [NUM_FREE];
    logic [3:0] home   [NUM_HOME];

    card_t      top       [NUM_COLS];
    logic [3:0] home_next [NUM_HOME];

    loc_kind_t  src_kind;
    loc_kind_t  dest_kind;
    card_t      src_card;
    card_t      dest_card;
    logic       src_ok;
    logic       dest_room;
    logic [3:0] home_rank;
    logic       legal;
    logic       win_next;

    logic [2:0] src_col;
    logic [2:0] dst_col;
    logic [1:0] src_free;
    logic [1:0] dst_free;

    assign src_kind  = loc_kind(source);
    assign dest_kind = loc_kind(dest);
    assign src_col   = source[2:0];
    assign dst_col   = dest[2:0];
    assign src_free  = source[1:0];
    assign dst_free  = dest[1:0];

    // Top card of every column (rank 0 when the column is empty)
    always_comb begin
        for (int c = 0; c < NUM_COLS; c++) begin
            top[c] = '0;
            if (height[c] != 5'd0)
                top[c] = cols[c][height[c] - 5'd1];
        end
    end

    // Source and destination muxes feeding the legality check
    always_comb begin
        src_card  = '0;
        dest_card = '0;
        dest_room = 1'b1;
        src_ok    = (src_kind != LOC_HOME) && (source != dest);
        case (src_kind)
            LOC_COL:  src_card = top[src_col];
            LOC_FREE: src_card = free[src_free];
            default:  src_card = '0;
        endcase
        case (dest_kind)
            LOC_COL: begin
                dest_card = top[dst_col];
                // Capacity guard; unreachable with single-card play but keeps the write in range
                dest_room = (height[dst_col] < 5'(COL_DEPTH));
            end
            LOC_FREE: dest_card = free[dst_free];
            default:  dest_card = '0;
        endcase
        home_rank = home[src_card.suit];
    end

    freecell_move_check u_check (
        .src_card  (src_card),
        .src_ok    (src_ok),
        .dest_kind (dest_kind),
        .dest_card (dest_card),
        .dest_room (dest_room),
        .home_rank (home_rank),
        .legal     (legal)
    );

    // Next home ranks and win flag, so win rises on the committing edge
    always_comb begin
        for (int s = 0; s < NUM_HOME; s++)
            home_next[s] = home[s];
        if (legal && (dest_kind == LOC_HOME))
            home_next[src_card.suit] = home[src_card.suit] + 4'd1;
        win_next = 1'b1;
        for (int s = 0; s < NUM_HOME; s++)
            if (home_next[s] != RANK_KING)
                win_next = 1'b0;
    end

    // Board state: load the deal on reset, otherwise commit a legal move
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                height[c] <= (c < 4) ? 5'd7 : 5'd6;
                for (int r = 0; r < COL_DEPTH; r++)
                    cols[c][r] <= '0;
            end
            for (int k = 0; k < NUM_CARDS; k++)
                cols[k % NUM_COLS][k / NUM_COLS] <= INIT_DEAL[k];
            for (int f = 0; f < NUM_FREE; f++)
                free[f] <= '0;
            for (int s = 0; s < NUM_HOME; s++)
                home[s] <= 4'd0;
            win <= 1'b0;
        end else begin
            if (legal) begin
                if (src_kind == LOC_COL)
                    height[src_col] <= height[src_col] - 5'd1;
                else
                    free[src_free] <= '0;
                case (dest_kind)
                    LOC_COL: begin
                        cols[dst_col][height[dst_col]] <= src_card;
                        height[dst_col] <= height[dst_col] + 5'd1;
                    end
                    LOC_FREE: free[dst_free] <= src_card;
                    default: ;
                endcase
            end
            for (int s = 0; s < NUM_HOME; s++)
                home[s] <= home_next[s];
            win <= win_next;
        end
    end

endmodule

// File: tb/tb_my_freecell.sv
// Self-checking bench for my_freecell: a behavioural board model feeds a
// scoreboard queue, plus explicit checks of the scenarios of interest.
module tb_my_freecell;

    logic       clock;
    logic       reset;
    logic [3:0] source;
    logic [3:0] dest;
    logic       win;

    int checks = 0;
    int errors = 0;

    my_freecell dut (
        .clock  (clock),
        .reset  (reset),
        .source (source),
        .dest   (dest),
        .win    (win)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic        w;
        logic [39:0] h;
        logic [23:0] fr;
        logic [15:0] hm;
        logic [47:0] tops;
    } snap_t;

    snap_t sb_q [$];

    // Reference board
    logic [5:0] m_cols [8][19];
    logic [4:0] m_h    [8];
    logic [5:0] m_free [4];
    logic [3:0] m_home [4];
    logic       m_win;

    function automatic logic red(logic [5:0] c);
        return c[5] ^ c[4];
    endfunction

    function automatic logic [5:0] m_top(int c);
        if (m_h[c] == 0) return 6'h00;
        return m_cols[c][m_h[c] - 1];
    endfunction

    task automatic m_reset();
        for (int c = 0; c < 8; c++) begin
            for (int r = 0; r < 19; r++) m_cols[c][r] = 6'h00;
            m_h[c] = (c < 4) ? 5'd7 : 5'd6;
        end
        for (int k = 0; k < 52; k++)
            m_cols[k % 8][k / 8] = {2'(k % 4), 4'(13 - k / 4)};
        for (int i = 0; i < 4; i++) begin
            m_free[i] = 6'h00;
            m_home[i] = 4'd0;
        end
        m_win = 1'b0;
    endtask

    task automatic m_move(input int s, input int d);
        logic [5:0] c;
        logic [5:0] t;
        bit ok;
        ok = 0;
        c = 6'h00;
        if (s <= 11 && s != d) begin
            c = (s < 8) ? m_top(s) : m_free[s - 8];
            if (c[3:0] != 0) begin
                if (d < 8) begin
                    t = m_top(d);
                    ok = (t[3:0] == 0) ||
                         ((int'(t[3:0]) == int'(c[3:0]) + 1) && (red(t) != red(c)));
                end else if (d < 12) begin
                    ok = (m_free[d - 8][3:0] == 0);
                end else begin
                    ok = (int'(m_home[c[5:4]]) == int'(c[3:0]) - 1);
                end
            end
        end
        if (ok) begin
            if (s < 8) m_h[s] = m_h[s] - 1;
            else       m_free[s - 8] = 6'h00;
            if (d < 8) begin
                m_cols[d][m_h[d]] = c;
                m_h[d] = m_h[d] + 1;
            end else if (d < 12) begin
                m_free[d - 8] = c;
            end else begin
                m_home[c[5:4]] = m_home[c[5:4]] + 1;
            end
        end
        m_win = (m_home[0] == 13) && (m_home[1] == 13) && (m_home[2] == 13) && (m_home[3] == 13);
    endtask

    function automatic snap_t m_snap();
        snap_t s;
        s.w = m_win;
        for (int c = 0; c < 8; c++) begin
            s.h[c*5 +: 5]    = m_h[c];
            s.tops[c*6 +: 6] = m_top(c);
        end
        for (int i = 0; i < 4; i++) begin
            s.fr[i*6 +: 6] = m_free[i];
            s.hm[i*4 +: 4] = m_home[i];
        end
        return s;
    endfunction

    function automatic snap_t dut_snap();
        snap_t s;
        s.w = win;
        for (int c = 0; c < 8; c++) begin
            s.h[c*5 +: 5]    = dut.height[c];
            s.tops[c*6 +: 6] = dut.top[c];
        end
        for (int i = 0; i < 4; i++) begin
            s.fr[i*6 +: 6] = dut.free[i];
            s.hm[i*4 +: 4] = dut.home[i];
        end
        return s;
    endfunction

    // Drive one move for exactly one cycle, then check the scoreboard entry
    task automatic do_move(input int s, input int d);
        snap_t exp_s;
        snap_t act_s;
        @(negedge clock);
        source = 4'(s);
        dest   = 4'(d);
        m_move(s, d);
        sb_q.push_back(m_snap());
        @(posedge clock);
        #1;
        act_s = dut_snap();
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty move %0d->%0d", s, d);
        end else begin
            exp_s = sb_q.pop_front();
            if (act_s !== exp_s) begin
                errors++;
                $display("FAIL move_%0d_to_%0d state got %h expected %h", s, d, act_s, exp_s);
            end
        end
        source = 4'd12;
        dest   = 4'd12;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        m_reset();
        #2;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (dut.height[0] !== 5'd7 || dut.top[0] !== 6'h01) begin
            errors++;
            $display("FAIL reset_col0 got h=%0d top=%h expected h=7 top=01", dut.height[0], dut.top[0]);
        end
        checks++;
        if (dut.height[4] !== 5'd6 || dut.top[4] !== 6'h02) begin
            errors++;
            $display("FAIL reset_col4 got h=%0d top=%h expected h=6 top=02", dut.height[4], dut.top[4]);
        end
        checks++;
        if (dut.top[7] !== 6'h32) begin
            errors++;
            $display("FAIL reset_col7_top got %h expected 32", dut.top[7]);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dut.free[i] !== 6'h00 || dut.home[i] !== 4'd0) begin
                errors++;
                $display("FAIL reset_cells_%0d got free=%h home=%0d expected 00 and 0", i, dut.free[i], dut.home[i]);
            end
        end
        checks++;
        if (win !== 1'b0) begin
            errors++;
            $display("FAIL reset_win got %b expected 0", win);
        end
    endtask

    task automatic test_home_build();
        do_reset();
        do_move(4, 12);
        checks++;
        if (dut.home[0] !== 4'd0 || dut.height[4] !== 5'd6) begin
            errors++;
            $display("FAIL home_reject got home=%0d h4=%0d expected 0 and 6", dut.home[0], dut.height[4]);
        end
        do_move(0, 12);
        checks++;
        if (dut.home[0] !== 4'd1 || dut.height[0] !== 5'd6) begin
            errors++;
            $display("FAIL home_ace got home=%0d h0=%0d expected 1 and 6", dut.home[0], dut.height[0]);
        end
        do_move(4, 13);
        checks++;
        if (dut.home[0] !== 4'd2 || dut.height[4] !== 5'd5) begin
            errors++;
            $display("FAIL home_two got home=%0d h4=%0d expected 2 and 5", dut.home[0], dut.height[4]);
        end
    endtask

    task automatic test_column_rules();
        do_reset();
        do_move(0, 4);
        checks++;
        if (dut.height[0] !== 5'd7 || dut.height[4] !== 5'd6) begin
            errors++;
            $display("FAIL same_colour got h0=%0d h4=%0d expected 7 and 6", dut.height[0], dut.height[4]);
        end
        do_move(0, 5);
        checks++;
        if (dut.height[5] !== 5'd7 || dut.top[5] !== 6'h01 || dut.height[0] !== 5'd6) begin
            errors++;
            $display("FAIL alt_colour got h5=%0d top5=%h h0=%0d expected 7 01 6", dut.height[5], dut.top[5], dut.height[0]);
        end
        do_reset();
        do_move(0, 8);
        checks++;
        if (dut.free[0] !== 6'h01) begin
            errors++;
            $display("FAIL free_fill got %h expected 01", dut.free[0]);
        end
        do_move(1, 8);
        checks++;
        if (dut.free[0] !== 6'h01 || dut.height[1] !== 5'd7) begin
            errors++;
            $display("FAIL free_occupied got free=%h h1=%0d expected 01 and 7", dut.free[0], dut.height[1]);
        end
    endtask

    task automatic test_illegal_sources();
        do_reset();
        do_move(12, 0);
        do_move(9, 0);
        do_move(3, 3);
        checks++;
        if (dut.height[0] !== 5'd7 || dut.height[3] !== 5'd7 || dut.free[1] !== 6'h00) begin
            errors++;
            $display("FAIL illegal_src got h0=%0d h3=%0d fb=%h expected 7 7 00", dut.height[0], dut.height[3], dut.free[1]);
        end
    endtask

    task automatic play_suit(input int s);
        for (int i = 0; i < 13; i++)
            do_move((i % 2 == 0) ? s : s + 4, 12);
    endtask

    task automatic test_win();
        int n;
        do_reset();
        n = 0;
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < 13; i++) begin
                do_move((i % 2 == 0) ? s : s + 4, 12);
                n++;
                checks++;
                if (win !== ((n == 52) ? 1'b1 : 1'b0)) begin
                    errors++;
                    $display("FAIL win_after_%0d got %b expected %b", n, win, (n == 52));
                end
            end
        end
        do_move(8, 12);
        checks++;
        if (win !== 1'b1) begin
            errors++;
            $display("FAIL win_sticky got %b expected 1", win);
        end
    endtask

    task automatic test_reset_midgame();
        do_reset();
        play_suit(0);
        for (int i = 0; i < 7; i++)
            do_move((i % 2 == 0) ? 1 : 5, 12);
        @(negedge clock);
        #2;
        reset = 1'b1;
        m_reset();
        #1;
        checks++;
        if (dut.height[0] !== 5'd7 || dut.top[0] !== 6'h01 || dut.home[0] !== 4'd0 ||
            dut.home[1] !== 4'd0 || dut.height[5] !== 5'd6 || win !== 1'b0) begin
            errors++;
            $display("FAIL midgame_reset got h0=%0d top0=%h home0=%0d home1=%0d h5=%0d win=%b expected 7 01 0 0 6 0",
                     dut.height[0], dut.top[0], dut.home[0], dut.home[1], dut.height[5], win);
        end
        @(negedge clock);
        reset = 1'b0;
        do_move(0, 12);
        checks++;
        if (dut.home[0] !== 4'd1) begin
            errors++;
            $display("FAIL after_reset_move got home=%0d expected 1", dut.home[0]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        source = 4'd12;
        dest   = 4'd12;
        m_reset();
        #12;
        reset = 1'b0;
        test_reset();
        test_home_build();
        test_column_rules();
        test_illegal_sources();
        test_win();
        test_reset_midgame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/my_freecell.md
# my_freecell

Single-player FreeCell game engine in hardware. It holds the full game state: 8 tableau columns, 4 free cells and 4 home foundations. Each clock cycle it applies one player move given as a source/destination location pair, if that move is legal. It raises `win` once all 52 cards reach home. It sits behind a move-entry front end or a game-playing bench.

## Interface
- No parameters. Deal and sizes are package constants.
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high; loads the initial deal.
- `source` in 4: location a card is taken from.
- `dest` in 4: location the card is placed on.
- `win` out 1: high when all four home cells hold kings; registered.
- Location codes:
  - 0–7 = tableau columns 1–8.
  - 8–11 = free cells a–d.
  - 12–15 = home; the two LSBs are ignored and the target home cell is chosen by the card's suit.

## Operation
- Card code is 6 bits: suit[5:4] (0 clubs, 1 diamonds, 2 hearts, 3 spades) and rank[3:0] (1 = A … 13 = K).
  - rank 0 means empty.
  - Red = suit[1] XOR suit[0].
- State:
  - 8 columns, each up to COL_DEPTH = 19 cards, with a 5-bit height per column.
  - 4 free cells, one card each.
  - 4 home cells, each storing only the top rank (0..13), indexed by suit.
- On reset:
  - Columns are loaded from INIT_DEAL: entry k goes to column k mod 8, row k div 8.
  - Columns 0–3 get 7 cards; columns 4–7 get 6.
  - Free cells and home cells are cleared; `win` = 0.
- Default INIT_DEAL[k]: rank = 13 − (k div 4), suit = k mod 4.
- A move is legal only if all of the following hold:
  - source is 0–11 and not empty (top card of a column, or the free-cell content);
  - source ≠ dest (dest values 12–15 are never equal to a legal source);
  - the destination rule holds:
    - column dest: column empty, OR top rank = card rank + 1 AND colours differ;
    - free-cell dest: cell empty;
    - home dest: home[suit].rank = card rank − 1.
- Only single-card moves are supported; no multi-card sequence moves.
- Legal move: remove the card from source (column height −1, or free cell cleared) and place it at dest (push, fill cell, or home rank +1).
- Illegal move: state is unchanged. No error output.
- `win` = all four home ranks = 13. Once high it stays high until reset, because no move can leave home.

## Timing
- `source`/`dest` are sampled on every rising `clock` edge. Each edge evaluates and commits at most one move.
- A move presented for N cycles is attempted N times. The driver holds each move for exactly one cycle.
- New state is visible from the committing edge. `win` rises on the same edge that commits the 52nd home placement.
- `reset` asserted at any time, including mid-game, restores the deal asynchronously. It must deassert synchronously to `clock`.

## Structure
- Package `freecell_pkg` holds:
  - card typedef (suit, rank);
  - location code constants;
  - COL_DEPTH = 19, NUM_COLS = 8, NUM_FREE = 4;
  - the INIT_DEAL[0:51] constant table.
- Sub-module `freecell_move_check` is combinational. It takes the source card, the dest top card or emptiness, and the home rank for the card's suit, and outputs `legal`.
- The top level holds the state registers, the source/dest muxes, the update logic and the `win` register.

## Test plan
- Reset:
  - Col 0 height 7 with top A♣ (code 0x01); col 4 height 6 with top 2♣ (0x02); col 7 top 2♠.
  - All free cells and homes empty; `win` = 0.
- Home build:
  - 0→12 gives home♣ = 1 and col 0 height 6.
  - Then 4→13 gives home♣ = 2.
  - 4→12 tried first from reset is rejected with no state change.
- Column rules:
  - 0→5 (A♣ onto 2♦) is accepted; col 5 height 7.
  - From reset, 0→4 (A♣ onto 2♣, same colour) is rejected.
  - After 0→8, 1→8 is rejected because the free cell is occupied.
- Illegal sources:
  - 12→0, 9→0 with cell b empty, and 3→3 each leave the state unchanged.
- Win:
  - For each suit s, alternate moves s→12 and (s+4)→12, 13 moves per suit.
  - `win` stays 0 through the 51st move and goes to 1 on the 52nd commit.
  - A further illegal 8→12 keeps `win` = 1.
- Reset mid-game:
  - After 20 moves, assert `reset` between edges: the deal is restored immediately and `win` = 0.
